// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Definitions shared by the button gesture decoder and its tick timer:
//   - FSM state encoding (3 bits)
//   - default timing constants (1 ms tick at 100 MHz)
//   - reset value of the registered previous button level
//   - small constant helper used to size the tick counter
// -----------------------------------------------------------------------------
package button_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } state_e;

  // Default timing: clk cycles per tick, long-press hold, double-click gap.
  localparam int TICK_DIV_DEF     = 100000;
  localparam int LONG_TICKS_DEF   = 800;
  localparam int DCLICK_TICKS_DEF = 300;

  // The previous level resets to "pressed" so a button held through reset
  // release must be released before it can register as a new press.
  localparam logic PREV_LEVEL_RST = 1'b1;

  // Larger of two integers, used for sizing at elaboration time.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : button_pkg

// File: rtl/gesture_tick_timer.sv
// -----------------------------------------------------------------------------
// gesture_tick_timer
// Prescaler plus saturating tick counter. A clear restarts both counters; the
// timeout output is high in the cycle just before the clk edge that lies
// exactly limit_i * TICK_DIV edges after the edge on which clear_i was seen,
// so a consumer that acts on timeout_o acts on that edge.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   clear_i    restart prescaler and tick counter on the next clk edge
//   limit_i    timeout threshold in ticks (must be at least 1)
//   timeout_o  threshold reached (derived only from registers)
// -----------------------------------------------------------------------------
module gesture_tick_timer
  import button_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int TW       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic [TW-1:0] limit_i,
  output logic          timeout_o
);

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_MAX   = {TW{1'b1}};
  localparam logic [TW-1:0] TICK_ONE   = TW'(1);

  logic [PW-1:0] presc_q;
  logic [TW-1:0] tick_q;

  // Prescaler wraps every TICK_DIV cycles; tick counter steps on each wrap
  // and sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= {PW{1'b0}};
      tick_q  <= {TW{1'b0}};
    end else if (clear_i) begin
      presc_q <= {PW{1'b0}};
      tick_q  <= {TW{1'b0}};
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= {PW{1'b0}};
      if (tick_q != TICK_MAX) begin
        tick_q <= tick_q + TICK_ONE;
      end else begin
        tick_q <= tick_q;
      end
    end else begin
      presc_q <= presc_q + PW'(1);
      tick_q  <= tick_q;
    end
  end

  // limit_i full ticks have elapsed once the last prescaler cycle of tick
  // (limit_i - 1) is in progress; the consumer's next edge is then exactly
  // limit_i * TICK_DIV edges after the clear.
  always_comb begin
    timeout_o = (presc_q == PRESC_LAST) && (tick_q == (limit_i - TICK_ONE));
  end

endmodule : gesture_tick_timer

// File: rtl/button_gesture_decoder.sv
// -----------------------------------------------------------------------------
// button_gesture_decoder
// Classifies debounced button activity into single click, double click and
// long press, emitting exactly one registered one-cycle pulse per gesture.
// All thresholds are counted in prescaled ticks.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   btn_level  debounced button level, synchronous to clk, 1 = pressed
//   single_o   one-cycle pulse: single click
//   double_o   one-cycle pulse: double click
//   long_o     one-cycle pulse: long press
//   busy_o     high whenever the FSM is not in IDLE
//   state_o    current FSM state encoding (debug)
// -----------------------------------------------------------------------------
module button_gesture_decoder
  import button_pkg::*;
#(
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int LONG_TICKS   = LONG_TICKS_DEF,
  parameter int DCLICK_TICKS = DCLICK_TICKS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_level,
  output logic               single_o,
  output logic               double_o,
  output logic               long_o,
  output logic               busy_o,
  output logic [STATE_W-1:0] state_o
);

  localparam int            TW           = $clog2(max_int(LONG_TICKS, DCLICK_TICKS) + 1);
  localparam logic [TW-1:0] LONG_LIMIT   = TW'(LONG_TICKS);
  localparam logic [TW-1:0] DCLICK_LIMIT = TW'(DCLICK_TICKS);

  logic    prev_level_q;
  logic    rise_s;
  logic    fall_s;
  state_e  state_q;
  state_e  state_d;
  logic    single_q;
  logic    single_d;
  logic    double_q;
  logic    double_d;
  logic    long_q;
  logic    long_d;
  logic    busy_q;
  logic    clear_s;
  logic    timeout_s;
  logic [TW-1:0] limit_s;

  // Previous button level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_level_q <= PREV_LEVEL_RST;
    end else begin
      prev_level_q <= btn_level;
    end
  end

  // Press and release edges of the debounced level.
  always_comb begin
    rise_s = btn_level & ~prev_level_q;
    fall_s = ~btn_level & prev_level_q;
  end

  // Only the release-gap state uses the double-click window; every other
  // timed state measures hold time.
  always_comb begin
    if (state_q == WAIT2) begin
      limit_s = DCLICK_LIMIT;
    end else begin
      limit_s = LONG_LIMIT;
    end
  end

  gesture_tick_timer #(
    .TICK_DIV (TICK_DIV),
    .TW       (TW)
  ) u_tick_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (clear_s),
    .limit_i   (limit_s),
    .timeout_o (timeout_s)
  );

  // Next-state and gesture decision. Edges are tested before timeouts so an
  // edge landing on the same clk edge as a timeout always wins.
  always_comb begin
    state_d  = state_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_s) begin
          state_d = PRESS1;
        end else begin
          state_d = IDLE;
        end
      end
      PRESS1: begin
        if (fall_s) begin
          state_d = WAIT2;
        end else if (timeout_s) begin
          long_d  = 1'b1;
          state_d = HOLD;
        end else begin
          state_d = PRESS1;
        end
      end
      WAIT2: begin
        if (rise_s) begin
          state_d = PRESS2;
        end else if (timeout_s) begin
          single_d = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = WAIT2;
        end
      end
      PRESS2: begin
        if (fall_s) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end else if (timeout_s) begin
          // Held too long on the second press: the first click is dropped.
          long_d  = 1'b1;
          state_d = HOLD;
        end else begin
          state_d = PRESS2;
        end
      end
      HOLD: begin
        if (fall_s) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Every transition changes state, so a state change marks an entry edge
  // and restarts the timer on that same edge.
  always_comb begin
    clear_s = (state_d != state_q);
  end

  // State register with registered pulses and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      single_q <= single_d;
      double_q <= double_d;
      long_q   <= long_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign single_o = single_q;
  assign double_o = double_q;
  assign long_o   = long_q;
  assign busy_o   = busy_q;
  assign state_o  = state_q;

endmodule : button_gesture_decoder

// File: tb/tb_button_gesture_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_gesture_decoder
// Drives press/release sequences and compares every observed pulse (type and
// clk edge of the decision) against a gesture-level reference model that works
// only from the recorded press/release edge numbers.
// Event code = decision_edge * 4 + type (1 single, 2 double, 3 long).
// -----------------------------------------------------------------------------
module tb_button_gesture_decoder;
  import button_pkg::*;

  localparam int TDIV     = 4;
  localparam int LTICKS   = 5;
  localparam int DTICKS   = 3;
  localparam int LONG_CYC = LTICKS * TDIV;  // 20 cycles
  localparam int DCL_CYC  = DTICKS * TDIV;  // 12 cycles

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_level;
  logic       single_o;
  logic       double_o;
  logic       long_o;
  logic       busy_o;
  logic [2:0] state_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int edge_cnt     = 0;
  int busy_cnt     = 0;
  int ev_q[$];
  int exp_q[$];
  int ps_q[$];
  int pe_q[$];

  button_gesture_decoder #(
    .TICK_DIV     (TDIV),
    .LONG_TICKS   (LTICKS),
    .DCLICK_TICKS (DTICKS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_level (btn_level),
    .single_o  (single_o),
    .double_o  (double_o),
    .long_o    (long_o),
    .busy_o    (busy_o),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  // Count rising clk edges; edge N is the Nth posedge.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Record pulses on the falling edge, tagged with the edge that produced them.
  always @(negedge clk) begin
    if (single_o) ev_q.push_back(edge_cnt * 4 + 1);
    if (double_o) ev_q.push_back(edge_cnt * 4 + 2);
    if (long_o)   ev_q.push_back(edge_cnt * 4 + 3);
    if (busy_o)   busy_cnt <= busy_cnt + 1;
  end

  // Press for h sampled edges, then release; logs the rise and fall edges.
  task automatic press(input int h);
    ps_q.push_back(edge_cnt + 1);
    btn_level = 1'b1;
    repeat (h) @(negedge clk);
    pe_q.push_back(edge_cnt + 1);
    btn_level = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Gesture rules: a press held longer than the long threshold is a long
  // press; otherwise a next press starting within the window (tie included)
  // makes a double click (or a long press if that one is held too long);
  // otherwise a single click fires one window after the release.
  task automatic compute_expected();
    int i;
    exp_q.delete();
    i = 0;
    while (i < ps_q.size()) begin
      if (pe_q[i] - ps_q[i] > LONG_CYC) begin
        exp_q.push_back((ps_q[i] + LONG_CYC) * 4 + 3);
        i = i + 1;
      end else if ((i + 1 < ps_q.size()) && (ps_q[i+1] - pe_q[i] <= DCL_CYC)) begin
        if (pe_q[i+1] - ps_q[i+1] > LONG_CYC) exp_q.push_back((ps_q[i+1] + LONG_CYC) * 4 + 3);
        else exp_q.push_back(pe_q[i+1] * 4 + 2);
        i = i + 2;
      end else begin
        exp_q.push_back((pe_q[i] + DCL_CYC) * 4 + 1);
        i = i + 1;
      end
    end
  endtask

  task automatic test_reset_held();
    int base;
    int busy0;
    rst_n = 1'b0;
    btn_level = 1'b1;
    idle(3);
    tests_run++;
    if ({single_o, double_o, long_o, busy_o} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 0000", {single_o, double_o, long_o, busy_o});
    end
    tests_run++;
    if (state_o !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d expected 0", state_o);
    end
    base = ev_q.size();
    busy0 = busy_cnt;
    rst_n = 1'b1;
    idle(100);
    btn_level = 1'b0;
    idle(30);
    tests_run++;
    if (ev_q.size() - base !== 0) begin
      tests_failed++;
      $display("FAIL reset_held_pulses: got %0d pulses expected 0", ev_q.size() - base);
    end
    tests_run++;
    if (busy_cnt - busy0 !== 0) begin
      tests_failed++;
      $display("FAIL reset_held_busy: got %0d busy cycles expected 0", busy_cnt - busy0);
    end
  endtask

  task automatic test_single();
    int base;
    ps_q.delete(); pe_q.delete();
    base = ev_q.size();
    press(6);
    idle(24);
    compute_expected();
    tests_run++;
    if (ev_q.size() - base !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL single_count: got %0d expected %0d", ev_q.size() - base, exp_q.size());
    end
    foreach (exp_q[i]) if (base + i < ev_q.size()) begin
      tests_run++;
      if (ev_q[base+i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL single_event: got type %0d @%0d expected type %0d @%0d",
                 ev_q[base+i] % 4, ev_q[base+i] / 4, exp_q[i] % 4, exp_q[i] / 4);
      end
    end
  endtask

  task automatic test_double();
    int base;
    ps_q.delete(); pe_q.delete();
    base = ev_q.size();
    press(5);
    idle(4);
    press(5);
    idle(24);
    compute_expected();
    tests_run++;
    if (ev_q.size() - base !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL double_count: got %0d expected %0d", ev_q.size() - base, exp_q.size());
    end
    foreach (exp_q[i]) if (base + i < ev_q.size()) begin
      tests_run++;
      if (ev_q[base+i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL double_event: got type %0d @%0d expected type %0d @%0d",
                 ev_q[base+i] % 4, ev_q[base+i] / 4, exp_q[i] % 4, exp_q[i] / 4);
      end
    end
  endtask

  task automatic test_long();
    int base;
    ps_q.delete(); pe_q.delete();
    base = ev_q.size();
    press(30);
    tests_run++;
    if (busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL long_busy_hold: got %b expected 1", busy_o);
    end
    idle(1);
    tests_run++;
    if (busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL long_busy_release: got %b expected 0", busy_o);
    end
    idle(24);
    // Hold of exactly the long threshold: release ties the timeout and wins.
    press(LONG_CYC);
    idle(24);
    compute_expected();
    tests_run++;
    if (ev_q.size() - base !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL long_count: got %0d expected %0d", ev_q.size() - base, exp_q.size());
    end
    foreach (exp_q[i]) if (base + i < ev_q.size()) begin
      tests_run++;
      if (ev_q[base+i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL long_event: got type %0d @%0d expected type %0d @%0d",
                 ev_q[base+i] % 4, ev_q[base+i] / 4, exp_q[i] % 4, exp_q[i] / 4);
      end
    end
  endtask

  task automatic test_tie();
    int base;
    ps_q.delete(); pe_q.delete();
    base = ev_q.size();
    press(5);
    idle(DCL_CYC);      // second rise sampled exactly at window end
    ps_q.push_back(edge_cnt + 1);
    btn_level = 1'b1;
    idle(1);
    tests_run++;
    if (state_o !== 3'd3) begin
      tests_failed++;
      $display("FAIL tie_state: got %0d expected 3", state_o);
    end
    idle(4);
    pe_q.push_back(edge_cnt + 1);
    btn_level = 1'b0;
    idle(24);
    compute_expected();
    tests_run++;
    if (ev_q.size() - base !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL tie_count: got %0d expected %0d", ev_q.size() - base, exp_q.size());
    end
    foreach (exp_q[i]) if (base + i < ev_q.size()) begin
      tests_run++;
      if (ev_q[base+i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL tie_event: got type %0d @%0d expected type %0d @%0d",
                 ev_q[base+i] % 4, ev_q[base+i] / 4, exp_q[i] % 4, exp_q[i] / 4);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    base = ev_q.size();
    press(5);
    idle(6);            // now just after WAIT2 entry edge + 5
    tests_run++;
    if ({busy_o, state_o} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL mid_pre_reset: got busy %b state %0d expected busy 1 state 2", busy_o, state_o);
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({single_o, double_o, long_o, busy_o, state_o} !== 7'b0000000) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got %b expected 0000000",
               {single_o, double_o, long_o, busy_o, state_o});
    end
    idle(3);
    rst_n = 1'b1;
    idle(30);
    tests_run++;
    if (state_o !== 3'd0) begin
      tests_failed++;
      $display("FAIL mid_state_after: got %0d expected 0", state_o);
    end
    tests_run++;
    if (ev_q.size() - base !== 0) begin
      tests_failed++;
      $display("FAIL mid_pulses: got %0d pulses expected 0", ev_q.size() - base);
    end
  endtask

  task automatic test_random();
    int base;
    int n;
    for (int b = 0; b < 14; b++) begin
      ps_q.delete(); pe_q.delete();
      base = ev_q.size();
      n = $urandom_range(4, 1);
      for (int k = 0; k < n; k++) begin
        press($urandom_range(28, 1));
        if (k < n - 1) idle($urandom_range(16, 1));
      end
      idle(24);
      compute_expected();
      tests_run++;
      if (ev_q.size() - base !== exp_q.size()) begin
        tests_failed++;
        $display("FAIL random_count[%0d]: got %0d expected %0d", b, ev_q.size() - base, exp_q.size());
      end
      foreach (exp_q[i]) if (base + i < ev_q.size()) begin
        tests_run++;
        if (ev_q[base+i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL random_event[%0d]: got type %0d @%0d expected type %0d @%0d", b,
                   ev_q[base+i] % 4, ev_q[base+i] / 4, exp_q[i] % 4, exp_q[i] / 4);
        end
      end
    end
  endtask

  initial begin
    test_reset_held();
    test_single();
    test_double();
    test_long();
    test_tie();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_button_gesture_decoder
